btn_irq_gen: RTL and testbench



---
 rtl/btn_irq_gen_pkg.sv | 32 +++
 rtl/btn_irq_chan.sv | 143 ++++++++++++++
 rtl/btn_irq_gen.sv | 77 +++++++
 tb/tb_btn_irq_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_irq_gen_pkg.sv
// ----------------------------------------------------------------------------
// btn_irq_gen_pkg
// Shared definitions for the button interrupt generator:
//   - btn_state_e    : per-channel state (idle, pending, holdoff lockout)
//   - DEF_*          : default values for the top-level parameters
//   - holdoff_width  : width of the holdoff down-counter, never below 1 bit
// ----------------------------------------------------------------------------
package btn_irq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HOLDOFF = 2'd2
    } btn_state_e;

    localparam int DEF_NUM_BTN = 4;
    localparam int DEF_HOLDOFF = 16;
    localparam int DEF_CNT_W   = 8;

    // $clog2(1) is 0, so a zero holdoff still gets a one-bit counter.
    function automatic int holdoff_width(input int holdoff);
        int w;
        w = $clog2(holdoff + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : btn_irq_gen_pkg

// File: rtl/btn_irq_chan.sv
// ----------------------------------------------------------------------------
// btn_irq_chan
// One button channel: rising-edge detect on the debounced level, the
// IDLE/PENDING/HOLDOFF state machine, the holdoff lockout counter, the
// accepted-event counter and the sticky overrun flag.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   btn_level_i  in   debounced button level, synchronous to clk
//   irq_en_i     in   channel enable (capture and interrupt)
//   ack_i        in   acknowledge for this channel (already qualified)
//   pending_o    out  channel has an unacknowledged event
//   overrun_o    out  sticky: an edge was lost in PENDING or HOLDOFF
//   evt_count_o  out  accepted-event counter, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module btn_irq_chan
    import btn_irq_gen_pkg::*;
#(
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_level_i,
    input  logic             irq_en_i,
    input  logic             ack_i,
    output logic             pending_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] evt_count_o
);

    localparam int            HO_W    = holdoff_width(HOLDOFF);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);
    localparam logic [HO_W-1:0] HO_ONE  = HO_W'(1);
    localparam logic [HO_W-1:0] HO_ZERO = {HO_W{1'b0}};

    btn_state_e       state_q, state_d;
    logic             prev_q;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [HO_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_s;

    assign rise_s = btn_level_i & ~prev_q;

    // State, counters and flags; prev_q resets high so a button already
    // pressed at reset release is not seen as a new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prev_q    <= 1'b1;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            hold_q    <= HO_ZERO;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            prev_q    <= btn_level_i;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic for the channel FSM and its side counters.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;

        // An ack clears overrun; a lost edge in the same cycle re-sets it
        // below, so set has priority over clear.
        if (ack_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise_s && irq_en_i) begin
                    state_d   = ST_PENDING;
                    pending_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_PENDING: begin
                if (ack_i) begin
                    pending_d = 1'b0;
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                        hold_d  = HO_ZERO;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hold_d  = HO_LOAD;
                    end
                end else begin
                    state_d = ST_PENDING;
                end
                if (rise_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_d;
                end
            end

            ST_HOLDOFF: begin
                // Leave lockout on the cycle the counter reads 1; the <=
                // also recovers safely from a corrupted zero count.
                if (hold_q <= HO_ONE) begin
                    state_d = ST_IDLE;
                    hold_d  = HO_ZERO;
                end else begin
                    state_d = ST_HOLDOFF;
                    hold_d  = hold_q - HO_ONE;
                end
                if (rise_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_d;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
                hold_d    = HO_ZERO;
            end
        endcase
    end

    assign pending_o   = pending_q;
    assign overrun_o   = overrun_q;
    assign evt_count_o = cnt_q;

endmodule : btn_irq_chan

// File: rtl/btn_irq_gen.sv
// ----------------------------------------------------------------------------
// btn_irq_gen
// Turns rising edges on debounced button levels into latched, maskable
// pending events and drives one registered level interrupt to the PS.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   btn_level_i    in   [NUM_BTN]        debounced button levels
//   irq_en_i       in   [NUM_BTN]        per-channel capture/interrupt enable
//   irq_ack_i      in   1                single-cycle acknowledge strobe
//   ack_mask_i     in   [NUM_BTN]        channels acknowledged by irq_ack_i
//   irq_o          out  1                registered interrupt request
//   irq_pending_o  out  [NUM_BTN]        per-channel pending flags
//   overrun_o      out  [NUM_BTN]        per-channel sticky overrun flags
//   evt_count_o    out  [NUM_BTN*CNT_W]  channel i at [i*CNT_W +: CNT_W]
// ----------------------------------------------------------------------------
module btn_irq_gen
    import btn_irq_gen_pkg::*;
#(
    parameter int NUM_BTN = DEF_NUM_BTN,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_BTN-1:0]       btn_level_i,
    input  logic [NUM_BTN-1:0]       irq_en_i,
    input  logic                     irq_ack_i,
    input  logic [NUM_BTN-1:0]       ack_mask_i,
    output logic                     irq_o,
    output logic [NUM_BTN-1:0]       irq_pending_o,
    output logic [NUM_BTN-1:0]       overrun_o,
    output logic [NUM_BTN*CNT_W-1:0] evt_count_o
);

    logic [NUM_BTN-1:0] ack_vec_s;
    logic [NUM_BTN-1:0] pending_s;
    logic               irq_q, irq_d;

    assign ack_vec_s = {NUM_BTN{irq_ack_i}} & ack_mask_i;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_irq_chan #(
            .HOLDOFF (HOLDOFF),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .btn_level_i (btn_level_i[g]),
            .irq_en_i    (irq_en_i[g]),
            .ack_i       (ack_vec_s[g]),
            .pending_o   (pending_s[g]),
            .overrun_o   (overrun_o[g]),
            .evt_count_o (evt_count_o[g*CNT_W +: CNT_W])
        );
    end

    // Interrupt request is any enabled pending channel; enable gates only
    // the request, so a disabled channel keeps its pending flag.
    always_comb begin
        irq_d = |(pending_s & irq_en_i);
    end

    // Interrupt output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o         = irq_q;
    assign irq_pending_o = pending_s;

endmodule : btn_irq_gen

// File: tb/tb_btn_irq_gen.sv
module tb_btn_irq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn_a, en_a, mask_a;
    logic        ack_a;
    logic        irq_a;
    logic [3:0]  pend_a, ovr_a;
    logic [31:0] cnt_a;
    logic [3:0]  btn_b, en_b, mask_b;
    logic        ack_b;
    logic        irq_b;
    logic [3:0]  pend_b, ovr_b;
    logic [31:0] cnt_b;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    btn_irq_gen #(.NUM_BTN(4), .HOLDOFF(16), .CNT_W(8)) u_h16 (
        .clk(clk), .rst(rst), .btn_level_i(btn_a), .irq_en_i(en_a),
        .irq_ack_i(ack_a), .ack_mask_i(mask_a), .irq_o(irq_a),
        .irq_pending_o(pend_a), .overrun_o(ovr_a), .evt_count_o(cnt_a)
    );

    btn_irq_gen #(.NUM_BTN(4), .HOLDOFF(0), .CNT_W(8)) u_h0 (
        .clk(clk), .rst(rst), .btn_level_i(btn_b), .irq_en_i(en_b),
        .irq_ack_i(ack_b), .ack_mask_i(mask_b), .irq_o(irq_b),
        .irq_pending_o(pend_b), .overrun_o(ovr_b), .evt_count_o(cnt_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_a = 4'b0001; en_a = 4'hF; ack_a = 1'b0; mask_a = 4'h0;
        btn_b = 4'h0; en_b = 4'h0; ack_b = 1'b0; mask_b = 4'h0;
        repeat (3) tick;
        vec++; if (irq_a !== 1'b0) begin err++; $display("FAIL rst_hold_irq got=%b exp=0", irq_a); end
        rst = 1'b0;
        repeat (2) tick;
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL rst_rel_pend got=%b exp=0000", pend_a); end
        vec++; if (irq_a !== 1'b0) begin err++; $display("FAIL rst_rel_irq got=%b exp=0", irq_a); end
        vec++; if (cnt_a[7:0] !== 8'd0) begin err++; $display("FAIL rst_rel_cnt0 got=%0d exp=0", cnt_a[7:0]); end
        vec++; if (ovr_a !== 4'b0000) begin err++; $display("FAIL rst_rel_ovr got=%b exp=0000", ovr_a); end
        btn_a = 4'b0000;
        tick;
    endtask

    task automatic test_basic;
        btn_a = 4'b0100;
        tick; // edge k
        vec++; if (pend_a !== 4'b0100) begin err++; $display("FAIL basic_pend_k got=%b exp=0100", pend_a); end
        vec++; if (irq_a !== 1'b0) begin err++; $display("FAIL basic_irq_k got=%b exp=0", irq_a); end
        tick; // k+1
        vec++; if (irq_a !== 1'b1) begin err++; $display("FAIL basic_irq_k1 got=%b exp=1", irq_a); end
        vec++; if (cnt_a[23:16] !== 8'd1) begin err++; $display("FAIL basic_cnt1 got=%0d exp=1", cnt_a[23:16]); end
        ack_a = 1'b1; mask_a = 4'b0100;
        tick; // edge a
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL basic_ack_pend got=%b exp=0000", pend_a); end
        vec++; if (irq_a !== 1'b1) begin err++; $display("FAIL basic_ack_irq_a got=%b exp=1", irq_a); end
        ack_a = 1'b0; mask_a = 4'b0000;
        tick; // a+1
        vec++; if (irq_a !== 1'b0) begin err++; $display("FAIL basic_ack_irq_a1 got=%b exp=0", irq_a); end
        btn_a = 4'b0000;
        tick; tick; // a+2, a+3
        btn_a = 4'b0100;
        tick; // a+4: rise in holdoff
        vec++; if (ovr_a !== 4'b0100) begin err++; $display("FAIL basic_ho_ovr got=%b exp=0100", ovr_a); end
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL basic_ho_pend got=%b exp=0000", pend_a); end
        vec++; if (cnt_a[23:16] !== 8'd1) begin err++; $display("FAIL basic_ho_cnt got=%0d exp=1", cnt_a[23:16]); end
        btn_a = 4'b0000;
        repeat (11) tick; // a+5 .. a+15
        btn_a = 4'b0100;
        tick; // a+16: last holdoff cycle, still dropped
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL basic_ho_last got=%b exp=0000", pend_a); end
        btn_a = 4'b0000;
        tick; // a+17
        btn_a = 4'b0100;
        tick; // a+18: idle again
        vec++; if (pend_a !== 4'b0100) begin err++; $display("FAIL basic_re_pend got=%b exp=0100", pend_a); end
        vec++; if (cnt_a[23:16] !== 8'd2) begin err++; $display("FAIL basic_cnt2 got=%0d exp=2", cnt_a[23:16]); end
        ack_a = 1'b1; mask_a = 4'b0100;
        tick;
        vec++; if (ovr_a !== 4'b0000) begin err++; $display("FAIL basic_ovr_clr got=%b exp=0000", ovr_a); end
        ack_a = 1'b0; mask_a = 4'b0000; btn_a = 4'b0000;
        repeat (20) tick;
    endtask

    task automatic test_overrun;
        btn_a = 4'b0010; tick;
        btn_a = 4'b0000; tick;
        btn_a = 4'b0010; tick;
        btn_a = 4'b0000; tick;
        btn_a = 4'b0010; tick;
        vec++; if (ovr_a !== 4'b0010) begin err++; $display("FAIL ovr_set got=%b exp=0010", ovr_a); end
        vec++; if (cnt_a[15:8] !== 8'd1) begin err++; $display("FAIL ovr_cnt got=%0d exp=1", cnt_a[15:8]); end
        vec++; if (pend_a !== 4'b0010) begin err++; $display("FAIL ovr_pend got=%b exp=0010", pend_a); end
        btn_a = 4'b0000; tick;
        btn_a = 4'b0010; ack_a = 1'b1; mask_a = 4'b0010;
        tick; // ack and rise together
        vec++; if (ovr_a !== 4'b0010) begin err++; $display("FAIL ovr_set_wins got=%b exp=0010", ovr_a); end
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL ovr_ack_pend got=%b exp=0000", pend_a); end
        ack_a = 1'b0; mask_a = 4'b0000; btn_a = 4'b0000; tick;
        btn_a = 4'b0010; tick; // still in holdoff
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL ovr_in_ho got=%b exp=0000", pend_a); end
        vec++; if (cnt_a[15:8] !== 8'd1) begin err++; $display("FAIL ovr_ho_cnt got=%0d exp=1", cnt_a[15:8]); end
        btn_a = 4'b0000;
        repeat (20) tick;
    endtask

    task automatic test_mask;
        en_a = 4'b0000; btn_a = 4'b0001;
        tick; tick;
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL mask_pend got=%b exp=0000", pend_a); end
        vec++; if (cnt_a[7:0] !== 8'd0) begin err++; $display("FAIL mask_cnt0 got=%0d exp=0", cnt_a[7:0]); end
        vec++; if (irq_a !== 1'b0) begin err++; $display("FAIL mask_irq got=%b exp=0", irq_a); end
        btn_a = 4'b0000; tick;
        en_a = 4'b1000; btn_a = 4'b1000;
        tick;
        vec++; if (pend_a !== 4'b1000) begin err++; $display("FAIL mask_ch3_pend got=%b exp=1000", pend_a); end
        tick;
        vec++; if (irq_a !== 1'b1) begin err++; $display("FAIL mask_ch3_irq got=%b exp=1", irq_a); end
        en_a = 4'b0000;
        tick;
        vec++; if (irq_a !== 1'b0) begin err++; $display("FAIL mask_dis_irq got=%b exp=0", irq_a); end
        vec++; if (pend_a !== 4'b1000) begin err++; $display("FAIL mask_dis_pend got=%b exp=1000", pend_a); end
        en_a = 4'b1000;
        tick;
        vec++; if (irq_a !== 1'b1) begin err++; $display("FAIL mask_reen_irq got=%b exp=1", irq_a); end
        ack_a = 1'b1; mask_a = 4'b1000; tick;
        ack_a = 1'b0; mask_a = 4'b0000; btn_a = 4'b0000;
        repeat (20) tick;
    endtask

    task automatic test_multi;
        en_a = 4'hF; btn_a = 4'b1001;
        tick;
        vec++; if (pend_a !== 4'b1001) begin err++; $display("FAIL multi_pend got=%b exp=1001", pend_a); end
        tick;
        vec++; if (irq_a !== 1'b1) begin err++; $display("FAIL multi_irq got=%b exp=1", irq_a); end
        ack_a = 1'b1; mask_a = 4'b0000;
        tick;
        vec++; if (pend_a !== 4'b1001) begin err++; $display("FAIL multi_nomask got=%b exp=1001", pend_a); end
        mask_a = 4'b0001;
        tick;
        vec++; if (pend_a !== 4'b1000) begin err++; $display("FAIL multi_ack0_pend got=%b exp=1000", pend_a); end
        ack_a = 1'b0; mask_a = 4'b0000;
        tick;
        vec++; if (irq_a !== 1'b1) begin err++; $display("FAIL multi_ack0_irq got=%b exp=1", irq_a); end
        ack_a = 1'b1; mask_a = 4'b1000;
        tick;
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL multi_ack3_pend got=%b exp=0000", pend_a); end
        ack_a = 1'b0; mask_a = 4'b0000;
        tick;
        vec++; if (irq_a !== 1'b0) begin err++; $display("FAIL multi_ack3_irq got=%b exp=0", irq_a); end
        vec++; if (cnt_a[31:24] !== 8'd2) begin err++; $display("FAIL multi_cnt3 got=%0d exp=2", cnt_a[31:24]); end
        vec++; if (cnt_a[7:0] !== 8'd1) begin err++; $display("FAIL multi_cnt0 got=%0d exp=1", cnt_a[7:0]); end
        btn_a = 4'b0000;
        repeat (20) tick;
    endtask

    task automatic test_wrap;
        en_b = 4'hF;
        for (int i = 0; i < 256; i++) begin
            btn_b = 4'b0001; ack_b = 1'b0; mask_b = 4'b0000;
            tick;
            btn_b = 4'b0000; ack_b = 1'b1; mask_b = 4'b0001;
            tick;
            if (i == 254) begin
                vec++; if (cnt_b[7:0] !== 8'd255) begin err++; $display("FAIL wrap_255 got=%0d exp=255", cnt_b[7:0]); end
            end
        end
        ack_b = 1'b0; mask_b = 4'b0000;
        tick;
        vec++; if (cnt_b[7:0] !== 8'd0) begin err++; $display("FAIL wrap_0 got=%0d exp=0", cnt_b[7:0]); end
        vec++; if (ovr_b !== 4'b0000) begin err++; $display("FAIL wrap_ovr got=%b exp=0000", ovr_b); end
        vec++; if (pend_b !== 4'b0000) begin err++; $display("FAIL wrap_pend got=%b exp=0000", pend_b); end
    endtask

    task automatic test_midreset;
        en_a = 4'hF; btn_a = 4'b0100;
        tick;
        ack_a = 1'b1; mask_a = 4'b0100;
        tick; // ch2 into holdoff
        ack_a = 1'b0; mask_a = 4'b0000; btn_a = 4'b0110;
        tick; // ch1 pending
        tick;
        vec++; if (pend_a !== 4'b0010) begin err++; $display("FAIL mid_pre_pend got=%b exp=0010", pend_a); end
        vec++; if (irq_a !== 1'b1) begin err++; $display("FAIL mid_pre_irq got=%b exp=1", irq_a); end
        #2;
        rst = 1'b1;
        #1; // well before the next clock edge
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL mid_pend got=%b exp=0000", pend_a); end
        vec++; if (irq_a !== 1'b0) begin err++; $display("FAIL mid_irq got=%b exp=0", irq_a); end
        vec++; if (ovr_a !== 4'b0000) begin err++; $display("FAIL mid_ovr got=%b exp=0000", ovr_a); end
        vec++; if (cnt_a !== 32'd0) begin err++; $display("FAIL mid_cnt got=%h exp=0", cnt_a); end
        rst = 1'b0;
        tick;
        vec++; if (pend_a !== 4'b0000) begin err++; $display("FAIL mid_release got=%b exp=0000", pend_a); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overrun;
        test_mask;
        test_multi;
        test_wrap;
        test_midreset;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule : tb_btn_irq_gen
